// File: rtl/lut_arbiter_if.sv
// Handshake bundle for lut_arbiter: loader port plus branch and memory lookup ports.
// slave = arbiter side, master = requester/loader side.
interface lut_arbiter_if #(
    parameter int DW = 10,
    parameter int AW = 4
);
    logic          LoadStart;
    logic          LoadValid;
    logic [DW-1:0] LoadData;
    logic          LoadReady;
    logic          LoadDone;
    logic          Busy;

    logic          BrReq;
    logic [AW-1:0] BrIdx;
    logic          BrGnt;
    logic          BrValid;
    logic [DW-1:0] BrOut;

    logic          MemReq;
    logic [AW-1:0] MemIdx;
    logic          MemGnt;
    logic          MemValid;
    logic [DW-1:0] MemOut;

    modport slave (
        input  LoadStart, LoadValid, LoadData,
        output LoadReady, LoadDone, Busy,
        input  BrReq, BrIdx,
        output BrGnt, BrValid, BrOut,
        input  MemReq, MemIdx,
        output MemGnt, MemValid, MemOut
    );

    modport master (
        output LoadStart, LoadValid, LoadData,
        input  LoadReady, LoadDone, Busy,
        output BrReq, BrIdx,
        input  BrGnt, BrValid, BrOut,
        output MemReq, MemIdx,
        input  MemGnt, MemValid, MemOut
    );
endinterface

// File: rtl/lut_arbiter.sv
// Writable 16-entry PC-target / data-address table with one read port shared by
// the branch and load/store units, plus a sequential full-table loader.
// Ports: Clk, Reset (sync, active-high), bus (lut_arbiter_if.slave):
//   loader  LoadStart/LoadValid/LoadData -> LoadReady/LoadDone/Busy
//   branch  BrReq/BrIdx -> BrGnt/BrValid/BrOut
//   memory  MemReq/MemIdx -> MemGnt/MemValid/MemOut
module lut_arbiter #(
    parameter int DW           = 10,
    parameter int AW           = 4,
    parameter int STARVE_LIMIT = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    lut_arbiter_if.slave    bus
);
    localparam int DEPTH = 1 << AW;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_LOAD = 1'b1;

    localparam logic [DW-1:0] ENTRY5 = DW'(10'b1001101000);
    localparam logic [SW-1:0] SLIM   = SW'(STARVE_LIMIT);

    logic [0:0]    r_state;
    logic [AW-1:0] r_ptr;
    logic [SW-1:0] r_starve;
    logic [DW-1:0] r_table [DEPTH];
    logic [DW-1:0] r_br_out;
    logic [DW-1:0] r_mem_out;
    logic          r_br_valid;
    logic          r_mem_valid;
    logic          r_load_done;

    logic w_run;
    logic w_mem_pri;
    logic w_br_gnt;
    logic w_mem_gnt;
    logic w_wr;
    logic w_ptr_last;

    assign w_run      = (r_state == S_RUN);
    assign w_mem_pri  = (r_starve == SLIM);
    assign w_wr       = !w_run && bus.LoadValid;
    assign w_ptr_last = (r_ptr == {AW{1'b1}});

    // Branch wins ties until memory has lost STARVE_LIMIT times in a row.
    assign w_br_gnt  = w_run && bus.BrReq
                    && !(bus.MemReq && w_mem_pri);
    assign w_mem_gnt = w_run && bus.MemReq
                    && (!bus.BrReq || w_mem_pri);

    assign bus.BrGnt     = w_br_gnt;
    assign bus.MemGnt    = w_mem_gnt;
    assign bus.Busy      = !w_run;
    assign bus.LoadReady = !w_run;
    assign bus.LoadDone  = r_load_done;
    assign bus.BrValid   = r_br_valid;
    assign bus.BrOut     = r_br_out;
    assign bus.MemValid  = r_mem_valid;
    assign bus.MemOut    = r_mem_out;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_RUN;
            r_ptr       <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            unique case (r_state)
                S_RUN: begin
                    if (bus.LoadStart) begin
                        r_state <= S_LOAD;
                        r_ptr   <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.LoadValid) begin
                        // ptr naturally wraps 15 -> 0 on the final write
                        r_ptr <= r_ptr + 1'b1;
                        if (w_ptr_last) begin
                            r_state     <= S_RUN;
                            r_load_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Reset restores boot contents, discarding any partial load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= (i == 5) ? ENTRY5 : '0;
            end
        end else if (w_wr) begin
            r_table[r_ptr] <= bus.LoadData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_starve <= '0;
        end else if (w_mem_gnt || !bus.MemReq) begin
            r_starve <= '0;
        end else if (w_br_gnt && !w_mem_pri) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_br_out    <= '0;
            r_mem_out   <= '0;
            r_br_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
        end else begin
            r_br_valid  <= w_br_gnt;
            r_mem_valid <= w_mem_gnt;
            if (w_br_gnt) begin
                r_br_out <= r_table[bus.BrIdx];
            end
            if (w_mem_gnt) begin
                r_mem_out <= r_table[bus.MemIdx];
            end
        end
    end
endmodule
